// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache requester ports and the shared memory block port.
// The arbiter connects through the slave modport; requesters and memory model use master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W  = 10,
   parameter int BLOCK_W = 128
);
   logic               req0;
   logic               read_write0;
   logic [ADDR_W-1:0]  address0;
   logic [BLOCK_W-1:0] writeData0;
   logic               ack0;
   logic [BLOCK_W-1:0] readData0;

   logic               req1;
   logic               read_write1;
   logic [ADDR_W-1:0]  address1;
   logic [BLOCK_W-1:0] writeData1;
   logic               ack1;
   logic [BLOCK_W-1:0] readData1;

   logic               mem_enable;
   logic               mem_read_write;
   logic [ADDR_W-1:0]  mem_address;
   logic [BLOCK_W-1:0] mem_write_data;
   logic [BLOCK_W-1:0] mem_read_data;

   logic               busy;
   logic               owner;

   modport master (
      output req0, read_write0, address0, writeData0,
      input  ack0, readData0,
      output req1, read_write1, address1, writeData1,
      input  ack1, readData1,
      input  mem_enable, mem_read_write, mem_address, mem_write_data,
      output mem_read_data,
      input  busy, owner
   );

   modport slave (
      input  req0, read_write0, address0, writeData0,
      output ack0, readData0,
      input  req1, read_write1, address1, writeData1,
      output ack1, readData1,
      output mem_enable, mem_read_write, mem_address, mem_write_data,
      input  mem_read_data,
      output busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared main-memory block-port arbiter/sequencer for the I-cache (port 0) and D-cache (port 1).
// Define ROUND_ROBIN_EN to alternate priority on contention; otherwise port 1 always wins.
module mem_port_arbiter_chk (
   input logic clock,
   input logic reset,
   input logic ack0,
   input logic ack1,
   input logic mem_enable,
   input logic busy
);
   a_ack_exclusive: assert property (@(posedge clock) disable iff (reset) !(ack0 && ack1));
   a_enable_busy:   assert property (@(posedge clock) disable iff (reset) mem_enable |-> busy);
   a_ack_no_enable: assert property (@(posedge clock) disable iff (reset) (ack0 || ack1) |-> !mem_enable);
   a_ack_one_cycle: assert property (@(posedge clock) disable iff (reset) (ack0 || ack1) |=> !(ack0 || ack1));
endmodule

module mem_port_arbiter #(
   parameter int MEM_LATENCY = 4,
   parameter int ADDR_W      = 10,
   parameter int BLOCK_W     = 128
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   state_t             state_r;
   logic [3:0]         cnt_r;
   logic               owner_r;
   logic               busy_r;
   logic               ack0_r;
   logic               ack1_r;
   logic               mem_enable_r;
   logic               mem_rw_r;
   logic [ADDR_W-1:0]  mem_addr_r;
   logic [BLOCK_W-1:0] mem_wdata_r;
   logic [BLOCK_W-1:0] rdata0_r;
   logic [BLOCK_W-1:0] rdata1_r;

   logic               grant_s;
   logic               any_req_s;
   logic               sel_rw_s;
   logic [ADDR_W-1:0]  sel_addr_s;
   logic [BLOCK_W-1:0] sel_wdata_s;

`ifdef ROUND_ROBIN_EN
   logic               ptr_r;

   // Winner select: the pointer breaks ties, a lone requester always wins.
   always_comb begin
      if (bus.req0 && bus.req1) begin
         grant_s = ptr_r;
      end else if (bus.req1) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end
`else
   // Winner select: the data cache has fixed priority over the instruction cache.
   always_comb begin
      if (bus.req1) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end
`endif

   // Request mux feeding the latch taken on the grant edge.
   always_comb begin
      any_req_s = bus.req0 | bus.req1;
      if (grant_s) begin
         sel_rw_s    = bus.read_write1;
         sel_addr_s  = bus.address1;
         sel_wdata_s = bus.writeData1;
      end else begin
         sel_rw_s    = bus.read_write0;
         sel_addr_s  = bus.address0;
         sel_wdata_s = bus.writeData0;
      end
   end

   // Sequencer: grant, hold the memory port for MEM_LATENCY cycles, then pulse the ack.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         owner_r      <= 1'b0;
         busy_r       <= 1'b0;
         ack0_r       <= 1'b0;
         ack1_r       <= 1'b0;
         mem_enable_r <= 1'b0;
         mem_rw_r     <= 1'b0;
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_wdata_r  <= {BLOCK_W{1'b0}};
         rdata0_r     <= {BLOCK_W{1'b0}};
         rdata1_r     <= {BLOCK_W{1'b0}};
`ifdef ROUND_ROBIN_EN
         ptr_r        <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               ack0_r <= 1'b0;
               ack1_r <= 1'b0;
               if (any_req_s) begin
                  state_r      <= ACCESS;
                  cnt_r        <= LAT_M1;
                  owner_r      <= grant_s;
                  busy_r       <= 1'b1;
                  mem_enable_r <= 1'b1;
                  mem_rw_r     <= sel_rw_s;
                  // Memory works on whole 16-byte blocks.
                  mem_addr_r   <= {sel_addr_s[ADDR_W-1:4], 4'b0000};
                  if (sel_rw_s) begin
                     mem_wdata_r <= sel_wdata_s;
                  end
`ifdef ROUND_ROBIN_EN
                  ptr_r        <= ~grant_s;
`endif
               end
            end
            ACCESS: begin
               if (cnt_r == 4'd0) begin
                  state_r      <= DONE;
                  mem_enable_r <= 1'b0;
                  if (owner_r) begin
                     ack1_r <= 1'b1;
                  end else begin
                     ack0_r <= 1'b1;
                  end
                  if (!mem_rw_r) begin
                     if (owner_r) begin
                        rdata1_r <= bus.mem_read_data;
                     end else begin
                        rdata0_r <= bus.mem_read_data;
                     end
                  end
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            DONE: begin
               state_r <= IDLE;
               ack0_r  <= 1'b0;
               ack1_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r      <= IDLE;
               ack0_r       <= 1'b0;
               ack1_r       <= 1'b0;
               busy_r       <= 1'b0;
               mem_enable_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack0           = ack0_r;
   assign bus.ack1           = ack1_r;
   assign bus.readData0      = rdata0_r;
   assign bus.readData1      = rdata1_r;
   assign bus.mem_enable     = mem_enable_r;
   assign bus.mem_read_write = mem_rw_r;
   assign bus.mem_address    = mem_addr_r;
   assign bus.mem_write_data = mem_wdata_r;
   assign bus.busy           = busy_r;
   assign bus.owner          = owner_r;

   mem_port_arbiter_chk u_chk (
      .clock      (clock),
      .reset      (reset),
      .ack0       (ack0_r),
      .ack1       (ack1_r),
      .mem_enable (mem_enable_r),
      .busy       (busy_r)
   );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, contention/reset/latency-1 sequences,
// and a randomized run against a transaction-timing reference model.
module tb_mem_port_arbiter;
   localparam int LAT = 4;
   localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] DB = {4{32'hDEAD_BEEF}};
   localparam logic [127:0] DC = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C;
   localparam logic [127:0] D1 = {8{16'h1111}};
   localparam logic [127:0] Z  = 128'h0;

   typedef struct {
      logic         port;
      logic         rw;
      logic [9:0]   addr;
      logic [127:0] wdata;
      logic         preload;
      logic [127:0] mdata;
      logic [9:0]   exp_maddr;
      int           exp_lat;
      logic [127:0] exp_rd0;
      logic [127:0] exp_rd1;
   } vec_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   logic [127:0] env_mem [64];
   logic [127:0] ref_mem [64];
   vec_t vecs [6];

   mem_port_arbiter_if #(.ADDR_W(10), .BLOCK_W(128)) b4 ();
   mem_port_arbiter_if #(.ADDR_W(10), .BLOCK_W(128)) b1 ();

   mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(10), .BLOCK_W(128)) dut4 (
      .clock (clk),
      .reset (rst),
      .bus   (b4.slave)
   );

   mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(10), .BLOCK_W(128)) dut1 (
      .clock (clk),
      .reset (rst),
      .bus   (b1.slave)
   );

   function automatic logic [127:0] pat1(input logic [9:0] a);
      return {8{a, 6'h2B}};
   endfunction

   assign b4.mem_read_data = env_mem[b4.mem_address[9:4]];
   assign b1.mem_read_data = pat1(b1.mem_address);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // One clock: sample point is 1 time unit after the edge; the memory model commits writes here.
   task automatic tick();
      @(posedge clk);
      #1;
      if (b4.mem_enable && b4.mem_read_write) env_mem[b4.mem_address[9:4]] = b4.mem_write_data;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      int en_cnt;
      bit seen;
      bit hold_ok;
      string tag;
      tag = $sformatf("vec%0d", idx);
      if (v.preload) env_mem[v.addr[9:4]] = v.mdata;
      if (v.port) begin
         b4.req1 = 1'b1; b4.read_write1 = v.rw; b4.address1 = v.addr; b4.writeData1 = v.wdata;
      end else begin
         b4.req0 = 1'b1; b4.read_write0 = v.rw; b4.address0 = v.addr; b4.writeData0 = v.wdata;
      end
      lat = 0; en_cnt = 0; seen = 1'b0; hold_ok = 1'b1;
      while (!seen && lat < 40) begin
         tick();
         lat++;
         if (lat == 1) begin
            // Inputs disturbed after the grant must not reach the memory port.
            if (v.port) begin b4.address1 = ~v.addr; b4.writeData1 = ~v.wdata; end
            else begin b4.address0 = ~v.addr; b4.writeData0 = ~v.wdata; end
         end
         if (b4.mem_enable) begin
            en_cnt++;
            if (b4.mem_address !== v.exp_maddr || b4.mem_read_write !== v.rw) hold_ok = 1'b0;
            if (v.rw && b4.mem_write_data !== v.wdata) hold_ok = 1'b0;
         end
         if ((v.port ? b4.ack0 : b4.ack1) !== 1'b0) hold_ok = 1'b0;
         seen = v.port ? b4.ack1 : b4.ack0;
      end
      b4.req0 = 1'b0;
      b4.req1 = 1'b0;
      check({tag, "_lat"}, lat, v.exp_lat);
      check({tag, "_en_cycles"}, en_cnt, LAT);
      check({tag, "_hold"}, hold_ok, 1'b1);
      check({tag, "_rdata"}, {b4.readData1, b4.readData0}, {v.exp_rd1, v.exp_rd0});
      tick();
      check({tag, "_ack_clear"}, {b4.ack1, b4.ack0, b4.busy}, 3'b000);
   endtask

   task automatic new_txn(input int p);
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      if (p == 1) begin
         b4.req1 = 1'b1; b4.read_write1 = 1'($urandom_range(0, 1));
         b4.address1 = 10'($urandom); b4.writeData1 = d;
      end else begin
         b4.req0 = 1'b1; b4.read_write0 = 1'($urandom_range(0, 1));
         b4.address0 = 10'($urandom); b4.writeData0 = d;
      end
   endtask

   // Random-phase reference model state.
   int k, g, next_ok, t, t0, t1, n0, n1, nen;
   logic w, gw, grw, e_en, e_busy, e_a0, e_a1;
   logic [9:0] gaddr;
   logic [127:0] gwd, exp_rd0, exp_rd1;
   logic [3:0] order;
   int n_ack;
   bit gap_ok;
   int last_ack;
`ifdef ROUND_ROBIN_EN
   logic ptr_m;
`endif

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      {b4.req0, b4.read_write0, b4.req1, b4.read_write1} = 4'b0000;
      {b4.address0, b4.address1} = 20'h0;
      {b4.writeData0, b4.writeData1} = {Z, Z};
      {b1.req0, b1.read_write0, b1.req1, b1.read_write1} = 4'b0000;
      {b1.address0, b1.address1} = 20'h0;
      {b1.writeData0, b1.writeData1} = {Z, Z};
      for (int i = 0; i < 64; i++) env_mem[i] = {4{32'(i) * 32'h0101_0101}};

      //            port  rw    addr    wdata preld mdata maddr   lat rd0 rd1
      vecs[0] = '{1'b0, 1'b0, 10'h2A7, Z,  1'b1, D0, 10'h2A0, 5, D0, Z};
      vecs[1] = '{1'b1, 1'b1, 10'h3F0, DB, 1'b0, Z,  10'h3F0, 5, D0, Z};
      vecs[2] = '{1'b1, 1'b0, 10'h155, Z,  1'b1, DC, 10'h150, 5, D0, DC};
      vecs[3] = '{1'b0, 1'b1, 10'h00F, D1, 1'b0, Z,  10'h000, 5, D0, DC};
      vecs[4] = '{1'b0, 1'b0, 10'h3FC, Z,  1'b0, Z,  10'h3F0, 5, DB, DC};
      vecs[5] = '{1'b1, 1'b0, 10'h00A, Z,  1'b0, Z,  10'h000, 5, DB, D1};

      do_reset();
      check("reset_ctrl4", {b4.ack0, b4.ack1, b4.mem_enable, b4.mem_read_write, b4.busy, b4.owner}, 6'b0);
      check("reset_bus4", {b4.mem_address, b4.mem_write_data}, {10'h0, Z});
      check("reset_rdata4", {b4.readData1, b4.readData0}, {Z, Z});
      check("reset_all1", {b1.ack0, b1.ack1, b1.mem_enable, b1.busy, b1.owner, b1.readData0, b1.readData1}, 261'h0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Reset during the second ACCESS cycle of a port 0 read abandons it.
      b4.req0 = 1'b1; b4.read_write0 = 1'b0; b4.address0 = 10'h2A7;
      tick();
      tick();
      rst = 1'b1;
      b4.req0 = 1'b0;
      tick();
      check("midreset_ctrl", {b4.mem_enable, b4.ack0, b4.ack1, b4.busy}, 4'b0000);
      check("midreset_rdata0", b4.readData0, Z);
      rst = 1'b0;
      n0 = 0; nen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n0 += int'(b4.ack0) + int'(b4.ack1);
         nen += int'(b4.mem_enable);
      end
      check("midreset_no_ack", {n0, nen}, 64'h0);
      check("midreset_rdata_kept", b4.readData0, Z);

      // Simultaneous requests, each requester drops after its ack.
      do_reset();
      b4.req0 = 1'b1; b4.read_write0 = 1'b1; b4.address0 = 10'h040; b4.writeData0 = DC;
      b4.req1 = 1'b1; b4.read_write1 = 1'b1; b4.address1 = 10'h080; b4.writeData1 = D1;
      t0 = 0; t1 = 0;
      for (t = 1; t <= 40 && (t0 == 0 || t1 == 0); t++) begin
         tick();
         if (b4.ack0) begin t0 = t; b4.req0 = 1'b0; end
         if (b4.ack1) begin t1 = t; b4.req1 = 1'b0; end
      end
`ifdef ROUND_ROBIN_EN
      check("contend_t0", t0, 5);
      check("contend_t1", t1, 11);
`else
      check("contend_t1", t1, 5);
      check("contend_t0", t0, 11);
`endif

      // Both requests held through four transactions: record grant order.
      do_reset();
      b4.req0 = 1'b1; b4.req1 = 1'b1;
      order = 4'b0000; n_ack = 0;
      for (int i = 0; i < 60 && n_ack < 4; i++) begin
         tick();
         if (b4.ack0 || b4.ack1) begin
            order[n_ack] = b4.ack1;
            n_ack++;
         end
      end
      b4.req0 = 1'b0; b4.req1 = 1'b0;
      check("held_acks", n_ack, 4);
`ifdef ROUND_ROBIN_EN
      check("held_order", order, 4'b1010);
`else
      check("held_order", order, 4'b1111);
`endif

      // Request dropped after grant still completes; dropped before grant never does.
      do_reset();
      b4.req1 = 1'b1; b4.read_write1 = 1'b1; b4.address1 = 10'h123; b4.writeData1 = DC;
      tick();
      b4.req1 = 1'b0;
      b4.req0 = 1'b1; b4.read_write0 = 1'b0; b4.address0 = 10'h200;
      tick();
      tick();
      b4.req0 = 1'b0;
      n0 = 0; n1 = 0; t1 = 0;
      for (t = 4; t <= 24; t++) begin
         tick();
         n0 += int'(b4.ack0);
         if (b4.ack1) begin n1++; t1 = t; end
      end
      check("drop_after_grant", {n1, t1}, {32'd1, 32'd5});
      check("drop_before_grant", n0, 0);

      // MEM_LATENCY=1: contention, then back-to-back reads on port 0.
      do_reset();
      b1.req0 = 1'b1; b1.read_write0 = 1'b0; b1.address0 = 10'h10C;
      b1.req1 = 1'b1; b1.read_write1 = 1'b0; b1.address1 = 10'h207;
      t0 = 0; t1 = 0;
      for (t = 1; t <= 20 && (t0 == 0 || t1 == 0); t++) begin
         tick();
         if (b1.ack0) begin t0 = t; b1.req0 = 1'b0; end
         if (b1.ack1) begin t1 = t; b1.req1 = 1'b0; end
      end
`ifdef ROUND_ROBIN_EN
      check("lat1_contend", {t0, t1}, {32'd2, 32'd5});
`else
      check("lat1_contend", {t1, t0}, {32'd2, 32'd5});
`endif
      check("lat1_rdata", {b1.readData1, b1.readData0}, {pat1(10'h200), pat1(10'h100)});
      tick();
      b1.req0 = 1'b1; b1.address0 = 10'h3A5;
      n0 = 0; nen = 0; gap_ok = 1'b1; last_ack = -1;
      for (t = 1; t <= 15; t++) begin
         tick();
         nen += int'(b1.mem_enable);
         if (b1.ack0) begin
            if (last_ack < 0 ? (t != 2) : (t - last_ack != 3)) gap_ok = 1'b0;
            last_ack = t;
            n0++;
         end
      end
      b1.req0 = 1'b0;
      check("b2b_acks", n0, 5);
      check("b2b_enable_cycles", nen, 5);
      check("b2b_spacing", gap_ok, 1'b1);
      check("b2b_rdata", b1.readData0, pat1(10'h3A0));

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 64; i++) ref_mem[i] = env_mem[i];
      exp_rd0 = Z; exp_rd1 = Z;
      g = -1000; next_ok = 0; k = 0;
      gw = 1'b0; grw = 1'b0; gaddr = 10'h0; gwd = Z;
`ifdef ROUND_ROBIN_EN
      ptr_m = 1'b0;
`endif
      for (int cyc = 0; cyc < 2500; cyc++) begin
         tick();
         k++;
         if (k >= next_ok && (b4.req0 || b4.req1)) begin
`ifdef ROUND_ROBIN_EN
            if (b4.req0 && b4.req1) w = ptr_m;
            else w = b4.req1;
            ptr_m = ~w;
`else
            w = b4.req1;
`endif
            g = k; gw = w;
            grw   = w ? b4.read_write1 : b4.read_write0;
            gaddr = w ? b4.address1 : b4.address0;
            gwd   = w ? b4.writeData1 : b4.writeData0;
            next_ok = k + LAT + 2;
            if (grw) ref_mem[gaddr[9:4]] = gwd;
         end
         e_en   = (k >= g) && (k <= g + LAT - 1);
         e_busy = (k >= g) && (k <= g + LAT);
         e_a0   = (k == g + LAT) && !gw;
         e_a1   = (k == g + LAT) && gw;
         if (k == g + LAT && !grw) begin
            if (gw) exp_rd1 = ref_mem[gaddr[9:4]];
            else exp_rd0 = ref_mem[gaddr[9:4]];
         end
         check("rnd_ctrl", {b4.ack1, b4.ack0, b4.mem_enable, b4.busy}, {e_a1, e_a0, e_en, e_busy});
         if (e_busy) check("rnd_port", {b4.owner, b4.mem_address, b4.mem_read_write},
                           {gw, gaddr[9:4], 4'h0, grw});
         check("rnd_rdata", {b4.readData1, b4.readData0}, {exp_rd1, exp_rd0});
         if (b4.req0) begin
            if (b4.ack0) begin
               if ($urandom_range(0, 1) == 1) new_txn(0);
               else b4.req0 = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            new_txn(0);
         end
         if (b4.req1) begin
            if (b4.ack1) begin
               if ($urandom_range(0, 1) == 1) new_txn(1);
               else b4.req1 = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            new_txn(1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Multi-cycle arbiter and sequencer for the single shared main-memory block port.
- Serves two cache requesters: port 0 is the instruction cache, port 1 is the data cache.
- Each transfer is one 128-bit block (4 words).
- Sits between the cache controllers and the memory model. The FSM serialises accesses, holds the memory signals stable for a fixed latency, and returns read blocks with a one-cycle acknowledge.

Parameters:
- MEM_LATENCY, 4, number of cycles the memory port is held per access; legal range 1..15.
- ADDR_W, 10, byte-address width.
- BLOCK_W, 128, block data width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- read_write0  in  1  port 0 operation; 0 = read block, 1 = write block.
- address0  in  ADDR_W  port 0 byte address.
- writeData0  in  BLOCK_W  port 0 write block.
- ack0  out  1  one-cycle done pulse, port 0.
- readData0  out  BLOCK_W  port 0 read block, valid with ack0.
- req1, read_write1, address1, writeData1, ack1, readData1: same as port 0, for port 1.
- mem_enable  out  1  memory access in progress.
- mem_read_write  out  1  0 = read, 1 = write.
- mem_address  out  ADDR_W  block address to memory.
- mem_write_data  out  BLOCK_W  block to memory.
- mem_read_data  in  BLOCK_W  block from memory.
- busy  out  1  FSM not IDLE.
- owner  out  1  port currently granted; valid while busy.

Behaviour:
- Reset (synchronous, active-high), output values:
  - state = IDLE.
  - ack0, ack1, mem_enable, mem_read_write, busy, owner = 0.
  - mem_address, mem_write_data, readData0, readData1 = 0.
  - Internal latency counter = 0; priority pointer = 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise, pick a winner per the arbitration rule. On the clock edge, latch owner, read_write, and the address with bits [3:0] forced to 0 (block-aligned). Latch the write block if writing. Load the counter with MEM_LATENCY-1 and go to ACCESS.
- ACCESS:
  - mem_enable = 1; mem_read_write, mem_address and mem_write_data are held at the latched values, unchanged for all MEM_LATENCY cycles.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: for a read, capture mem_read_data into readData<owner>; then go to DONE.
  - Writes commit at the end of the last ACCESS cycle.
- DONE:
  - ack<owner> = 1 for exactly this cycle; mem_enable = 0.
  - Next state is IDLE unconditionally.
- Latency: req sampled at edge N gives ack high during cycle N+MEM_LATENCY+1. A new grant is issued no earlier than 1 cycle after DONE.
- readDataX holds its value until the next read completes on that port. Writes never modify readDataX.
- Requester rules:
  - A requester must keep req, read_write, address and writeData stable until ack.
  - req still high in the cycle after ack is a new request.
  - Input changes after the grant edge are ignored; the latched copy is used.
- Arbitration (default build): fixed priority, port 1 (data) wins when both requesters are high.
- A request dropped before grant is never serviced. A request dropped after grant is completed and acked anyway.
- Both reqs high with MEM_LATENCY=1: accesses are strictly serialised, and the loser is granted in the IDLE cycle following DONE.
- Reset mid-operation: immediate return to IDLE next edge; mem_enable and acks deasserted; the in-flight transaction is abandoned (no ack, and readData keeps reset value 0). A partial write is tolerated by the memory model.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined:
  - A 1-bit priority pointer (reset 0) selects the preferred port when both reqs are high.
  - After each grant, the pointer moves to the non-granted port.
  - A single requester is always granted regardless of the pointer.
- Undefined: fixed priority to port 1; the pointer logic is absent.

Test Plan:
- Reset, then port 0 read address 10'h2A7 with MEM_LATENCY=4 and memory returning 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 -> mem_address=10'h2A0, mem_enable high for 4 cycles, ack0 pulses 5 cycles after req, readData0 equals the returned block.
- Port 1 write address 10'h3F0 with data 128'hDEAD_BEEF_x4 -> mem_read_write=1 and mem_write_data stable for 4 cycles, ack1 one cycle, readData1 unchanged.
- req0 and req1 high in the same cycle, fixed priority -> port 1 served first, port 0 acked 6 cycles later; with ROUND_ROBIN_EN, port 0 first, then port 1.
- ROUND_ROBIN_EN with both reqs held continuously for 4 transactions -> grants alternate 0,1,0,1; never two consecutive grants to the same port.
- reset asserted during the 2nd ACCESS cycle of a port 0 read -> next cycle: state IDLE, mem_enable=0, no ack0, readData0=0.
- MEM_LATENCY=1, back-to-back port 0 requests with req held high -> ack0 every 3 cycles, mem_enable high 1 cycle per access.
